handshake_stream_checker: RTL
=============================

# handshake_stream_checker

Receiving-end endpoint for the team's 32-bit valid/ready handshake streams: it acts as the downstream consumer of a pipe stage and drives `master_ready` with a programmable back-pressure pattern. Each accepted beat is checked against an incrementing reference sequence. The block also flags upstream handshake-protocol violations. It terminates the output side of the handshake pipe slices in unit and system benches, and sits behind stream sources on the test-harness FPGA build.

## Interface
Parameters:
- `DATA_W`, 32, stream data width
- `CNT_W`, 16, width of beat and error counters

Ports:
- `clk`  in  1  single clock, all logic rising-edge
- `rst_n`  in  1  asynchronous active-low reset
- `master_valid`  in  1  upstream valid
- `master_data`  in  DATA_W  upstream data
- `master_ready`  out  1  ready to upstream, driven from a register
- `start`  in  1  pulse: clear counters, load reference, enter RUN
- `stop`  in  1  pulse: return to IDLE
- `cfg_mode`  in  2  ready pattern: 0 = always, 1 = periodic, 2 = LFSR, 3 = never
- `cfg_period`  in  4  periodic mode: ready high 1 cycle in every `cfg_period`+1
- `cfg_seed`  in  16  LFSR seed, sampled on `start`
- `cfg_first`  in  DATA_W  expected value of the first beat, sampled on `start`
- `busy`  out  1  high in RUN
- `beat_cnt`  out  CNT_W  accepted beats, saturating
- `err_cnt`  out  CNT_W  data mismatches, saturating
- `err_flag`  out  1  sticky; set on the first mismatch
- `first_err_data` / `first_err_exp`  out  DATA_W  received and expected data of the first mismatch
- `proto_err`  out  1  sticky protocol violation

## Operation
- FSM has two states, IDLE and RUN; reset state is IDLE.
- IDLE to RUN on `start`.
- RUN to IDLE on `stop`.
- `start` in RUN is ignored. `stop` in IDLE is ignored.
- `start` and `stop` in the same cycle: `stop` wins, no state change, nothing cleared.
- On `start`:
  - clear `beat_cnt`, `err_cnt`, `err_flag`, `proto_err`, `first_err_*`
  - load `expect` ← `cfg_first`
  - load LFSR ← `cfg_seed`; if `cfg_seed` is 0, load 16'hACE1 instead
  - zero the period counter
- Ready pattern:
  - Next-state logic for `master_ready` never depends on `master_valid` or `master_data`.
  - IDLE: 0.
  - Mode 0: 1 every RUN cycle.
  - Mode 1: 1 when the period counter equals `cfg_period`, then the counter wraps to 0. `cfg_period` = 0 means always ready.
  - Mode 2: LFSR bit 0. The LFSR is Fibonacci x^16+x^14+x^13+x^11+1 and advances every RUN cycle.
  - Mode 3: 0.
- Handshake is `master_valid & master_ready`. Handshakes are counted only in RUN; a handshake in the cycle `stop` is sampled still counts.
- Check per handshake:
  - On `master_data != expect`: `err_cnt`+1. If `err_flag` is clear, capture `first_err_*` and set `err_flag`.
  - Always `expect` ← `master_data`+1 (mod 2^DATA_W). This resyncs, so one corrupted beat costs one error.
  - Wrap from all-ones to 0 is legal and is not an error.
- Protocol check (RUN only): if the previous cycle had `master_valid & !master_ready`, the current cycle must have `master_valid`=1 and unchanged `master_data`. Otherwise `proto_err` is set.
- Counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- Reset values: `master_ready` 0, `busy` 0, every counter, flag and capture register 0, LFSR 16'hACE1, `expect` 0.
- Reset asserted mid-RUN returns to IDLE immediately (asynchronous); status is lost.
- `start` sampled at edge N: `busy`=1 after N. First possible ready is cycle N+1, produced by the registered pattern.
- `stop` sampled at edge N: `master_ready`=0 and `busy`=0 from N+1.
- Status outputs update the cycle after the handshake edge; zero combinational paths from inputs to outputs.

## Structure
- Shared package `hs_pkg` holds:
  - `ready_mode_e` (ALWAYS, PERIODIC, LFSR, NEVER)
  - FSM state enum
  - LFSR taps constant and zero-seed substitute 16'hACE1
- One sub-module, `hs_lfsr16`: seed load, enable, parallel state out. It is reused by the team's matching stream source.

## Test plan
- Mode 0, `cfg_first`=0x10, source sends 0x10..0x1F back-to-back → `beat_cnt`=16, `err_cnt`=0, `master_ready` continuously 1.
- Mode 1, `cfg_period`=3 → ready high exactly 1 of every 4 cycles. 8 beats take 32 cycles, no errors.
- Sequence 0,1,2,7,8,9 → `err_cnt`=1, `first_err_data`=7, `first_err_exp`=3, `expect` resyncs to 10.
- Mode 2, seed 0 → LFSR loaded 16'hACE1, ready matches the reference model bit-for-bit. Stream 0xFFFFFFFE, 0xFFFFFFFF, 0 → no error across the wrap.
- Source drops valid while ready=0 (mode 3) → `proto_err`=1. A separate run where the source changes data while stalled also gives `proto_err`=1.
- `start`+`stop` same cycle in IDLE → stays IDLE. Reset pulse mid-stream → all outputs return to their reset values within the reset cycle.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared definitions for the valid/ready stream endpoints: ready-pattern
// modes, FSM state encoding and the 16-bit LFSR polynomial with its
// zero-seed substitute.
package hs_pkg;

  typedef enum logic [1:0] {
    MODE_ALWAYS   = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_LFSR     = 2'd2,
    MODE_NEVER    = 2'd3
  } ready_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned LFSR_W   = 16;
  localparam int unsigned PERIOD_W = 4;

  // Fibonacci x^16+x^14+x^13+x^11+1, right-shifting: feedback from bits 0,2,3,5
  localparam logic [LFSR_W-1:0] LFSR_TAPS      = 16'h002D;
  localparam logic [LFSR_W-1:0] LFSR_ZERO_SEED = 16'hACE1;

  // One LFSR step
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
  endfunction

  // An all-zero seed would lock the LFSR, so substitute a known-good one
  function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [LFSR_W-1:0] seed);
    return (seed == '0) ? LFSR_ZERO_SEED : seed;
  endfunction

endpackage

// File: rtl/hs_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load and step enable.
// Ports: clk, rst_n; load/seed (load takes priority, zero seed substituted);
// en (advance one step); state (registered value); state_nxt_c (value the
// register takes at the next edge, combinational).
module hs_lfsr16
  import hs_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state,
  output logic [LFSR_W-1:0] state_nxt_c
);

  // Next-state select
  always_comb begin
    state_nxt_c = state;
    if (load) begin
      state_nxt_c = lfsr_seed(seed);
    end else if (en) begin
      state_nxt_c = lfsr_step(state);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LFSR_ZERO_SEED;
    end else begin
      state <= state_nxt_c;
    end
  end

endmodule

// File: rtl/handshake_stream_checker.sv
// Consumer end of a valid/ready stream: drives a programmable registered
// back-pressure pattern on master_ready, checks accepted beats against an
// incrementing reference and flags upstream protocol violations.
// Ports: clk, rst_n; master_valid/master_data in, master_ready out;
// start/stop control pulses; cfg_mode/cfg_period/cfg_seed/cfg_first config;
// busy, beat_cnt, err_cnt, err_flag, first_err_data, first_err_exp,
// proto_err status (all registered).
module handshake_stream_checker
  import hs_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                master_valid,
  input  logic [DATA_W-1:0]   master_data,
  output logic                master_ready,
  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [LFSR_W-1:0]   cfg_seed,
  input  logic [DATA_W-1:0]   cfg_first,
  output logic                busy,
  output logic [CNT_W-1:0]    beat_cnt,
  output logic [CNT_W-1:0]    err_cnt,
  output logic                err_flag,
  output logic [DATA_W-1:0]   first_err_data,
  output logic [DATA_W-1:0]   first_err_exp,
  output logic                proto_err
);

  state_e              state_q, state_d;
  logic                load_c, run_c;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_nxt;
  logic                ready_d;
  logic [DATA_W-1:0]   exp_q;
  logic                stall_q;
  logic [DATA_W-1:0]   stall_data_q;
  logic                hs, mismatch, proto_bad;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; stop dominates start, so start+stop in IDLE is a no-op
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    run_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
          load_c  = 1'b1;
        end
      end
      ST_RUN: begin
        run_c = 1'b1;
        if (stop) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_RUN);

  // Pattern generator state for the cycle after this edge
  hs_lfsr16 u_lfsr (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load_c),
    .en          (run_c),
    .seed        (cfg_seed),
    .state       (lfsr_q),
    .state_nxt_c (lfsr_nxt)
  );

  // Only bit 0 of the upcoming LFSR value shapes ready here
  logic unused_lfsr;
  assign unused_lfsr = ^{lfsr_q, lfsr_nxt[LFSR_W-1:1]};

  // Period counter; wraps after reaching cfg_period (>= guards a shrinking period)
  always_comb begin
    per_d = per_q;
    if (load_c) begin
      per_d = '0;
    end else if (run_c) begin
      per_d = (per_q >= cfg_period) ? '0 : per_q + PERIOD_W'(1);
    end
  end

  // Ready for the next cycle, from pattern state only (never from valid/data)
  always_comb begin
    ready_d = 1'b0;
    if (state_d == ST_RUN) begin
      case (ready_mode_e'(cfg_mode))
        MODE_ALWAYS:   ready_d = 1'b1;
        MODE_PERIODIC: ready_d = (per_d == cfg_period);
        MODE_LFSR:     ready_d = lfsr_nxt[0];
        default:       ready_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      master_ready <= 1'b0;
      per_q        <= '0;
    end else begin
      master_ready <= ready_d;
      per_q        <= per_d;
    end
  end

  assign hs        = run_c & master_valid & master_ready;
  assign mismatch  = (master_data != exp_q);
  // A stalled beat must be held with identical data
  assign proto_bad = run_c & stall_q & (!master_valid || (master_data != stall_data_q));

  // Beat checking and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt       <= '0;
      err_cnt        <= '0;
      err_flag       <= 1'b0;
      first_err_data <= '0;
      first_err_exp  <= '0;
      proto_err      <= 1'b0;
      exp_q          <= '0;
    end else if (load_c) begin
      beat_cnt       <= '0;
      err_cnt        <= '0;
      err_flag       <= 1'b0;
      first_err_data <= '0;
      first_err_exp  <= '0;
      proto_err      <= 1'b0;
      exp_q          <= cfg_first;
    end else begin
      if (hs) begin
        if (beat_cnt != '1) begin
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
        // Resync to received data so one bad beat costs one error
        exp_q <= master_data + DATA_W'(1);
        if (mismatch) begin
          if (err_cnt != '1) begin
            err_cnt <= err_cnt + CNT_W'(1);
          end
          if (!err_flag) begin
            err_flag       <= 1'b1;
            first_err_data <= master_data;
            first_err_exp  <= exp_q;
          end
        end
      end
      if (proto_bad) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Remember a stalled beat for the next-cycle protocol check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q      <= 1'b0;
      stall_data_q <= '0;
    end else begin
      stall_q      <= run_c & master_valid & ~master_ready;
      stall_data_q <= master_data;
    end
  end

endmodule
